toaplan2_cen_gen: RTL and testbench
===================================

// Module: toaplan2_cen_gen
// PURPOSE
//  Parametrised multi-channel fractional clock-enable generator; successor to the per-core fixed-ratio CEN blocks.
//  Each channel emits a 1-cycle CEN pulse at f_clk*NUM/DEN plus a half-phase CENB pulse.
//  Ratios are reprogrammable at run time from the game-select logic, so one build can serve several Toaplan2 titles.
//  Sits beside the game top; feeds pixel, pixel x2, YM2151 (two enables) and OKI enables.
// PARAMETERS
//  NCH       6                 number of channels
//  W         16                width of NUM, DEN and accumulator, per channel
//  NUM_INIT  {6{16'd9}}        packed NCH*W reset numerators; channel 0 in LSBs
//  DEN_INIT  {64,128,256,512,216,128}  packed NCH*W reset denominators
// PORTS
//  CLK       in   1      system clock (96 MHz nominal)
//  RESET     in   1      asynchronous reset, active-high
//  CFG_WE    in   1      1-cycle strobe: write CFG_NUM/CFG_DEN into the shadow registers of channel CFG_CH
//  CFG_CH    in   $clog2(NCH)  channel index; an index >= NCH is ignored
//  CFG_NUM   in   W      new numerator
//  CFG_DEN   in   W      new denominator
//  CFG_IMM   in   1      with CFG_WE: 1 = apply the new ratio next cycle; 0 = apply it at the channel's next CEN
//  PAUSE     in   1      present only with TOAPLAN2_CEN_PAUSE_EN; freezes the channels selected by PAUSE_MASK
//  CEN       out  NCH    clock-enable pulses
//  CENB      out  NCH    half-phase pulses
//  CFG_PEND  out  NCH    a deferred ratio is waiting to be applied
// BEHAVIOUR
//  Reset: acc=0; num/den = *_INIT; CEN=0, CENB=0, CFG_PEND=0.
//  Per channel, per cycle: s = acc + num, computed at W+1 bits; wrap = (s >= den); acc_n = wrap ? s-den : s.
//  CEN(t+1) = wrap, registered; latency is one cycle from the accumulator crossing.
//  Let h = den>>1:
//   - no wrap: CENB(t+1) = (acc < h) && (s >= h);
//   - wrap: CENB(t+1) = (acc_n >= h).
//   - If CEN and CENB would fire in the same cycle, CENB is suppressed.
//  Degenerate ratios, checked in this order:
//   - den == 0 or num == 0: channel idle; acc holds; CEN = CENB = 0.
//   - num >= den: CEN = 1 every cycle; CENB = 0; acc = 0.
//  Accumulator invariant: acc < den always. A new den smaller than acc forces acc = 0 when the new ratio is applied.
//  Config, state per channel (IDLE/PEND):
//   - IDLE, CFG_WE & CFG_IMM: num/den updated next cycle; stay IDLE.
//   - IDLE, CFG_WE & !CFG_IMM: shadow loaded; -> PEND; CFG_PEND = 1.
//   - PEND, a CEN-producing cycle: the new ratio applies to the next cycle's accumulation; -> IDLE.
//   - PEND, another CFG_WE: shadow overwritten, last write wins; CFG_IMM=1 applies it at once -> IDLE.
//   - PEND while the channel is idle (den=0 or num=0): the deferred ratio applies immediately.
//  No CEN pulse is lost or duplicated across a ratio change. Phase is preserved (acc is kept) unless the acc < den fix forces 0.
//  RESET asserted mid-operation: every output clears asynchronously; pending configs are discarded.
// CONFIGURATION
//  TOAPLAN2_CEN_PAUSE_EN defined:
//   - adds the PAUSE port and a PAUSE_MASK parameter (NCH bits, default all 1).
//   - masked channels hold acc and output CEN = CENB = 0 while PAUSE = 1.
//   - PAUSE falling resumes from the held phase.
//   - deferred configs still apply immediately on a paused idle channel; otherwise they wait for the channel's next CEN.
//  Not defined: no PAUSE port; channels always run.
// STRUCTURE
//  Package toaplan2_cen_pkg:
//   - channel index constants CH_PXL2=0, CH_PXL=1, CH_FM=2, CH_FM2=3, CH_OKI=4, CH_AUX=5;
//   - per-title ratio constants for 96 MHz: 13.5=9/64, 6.75=9/128, 3.375=9/256, 1.6875=9/512, 4=9/216.
//  Sub-module toaplan2_cen_frac: one channel (accumulator, CENB logic, IDLE/PEND FSM), instantiated NCH times by generate.
// TESTING
//  1. Defaults, 1152 cycles after reset -> CEN[1] = 81 pulses; CEN[0] = 162; CEN[4] = 48; CENB[1] count = 81, each CENB midway between two CENs.
//  2. CFG_WE ch1 9/128 -> 9/64 with CFG_IMM=0 mid-period -> CFG_PEND[1]=1 until the next CEN[1]; the 13.5 MHz rate starts after that CEN; no extra or missing pulse.
//  3. CFG_WE ch2 den=0 -> CEN[2]/CENB[2] stay 0; then CFG_WE 9/256 -> pulses resume at 3.375 MHz.
//  4. CFG_WE ch5 num=5, den=5 -> CEN[5]=1 every cycle, CENB[5]=0; CFG_CH=7 -> no channel changes.
//  5. RESET pulse mid-run with ch3 PEND -> all outputs 0 asynchronously; after release, ch3 runs at DEN_INIT 9/512.
//  6. (PAUSE_EN) PAUSE=1 for 100 cycles -> no pulses on masked channels; the CEN count after release equals the count with those 100 cycles removed.

Source files
------------

// File: rtl/toaplan2_cen_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : toaplan2_cen_pkg
//  Description : Shared constants and types for the Toaplan2 fractional
//                clock-enable generator: channel indices, 96 MHz ratio
//                constants, default reset denominators and the per-channel
//                configuration state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package toaplan2_cen_pkg;

  // Channel assignment
  localparam int CH_PXL2 = 0;
  localparam int CH_PXL  = 1;
  localparam int CH_FM   = 2;
  localparam int CH_FM2  = 3;
  localparam int CH_OKI  = 4;
  localparam int CH_AUX  = 5;

  // Per-title ratios from a 96 MHz system clock
  localparam logic [15:0] R_13P5_NUM   = 16'd9;
  localparam logic [15:0] R_13P5_DEN   = 16'd64;
  localparam logic [15:0] R_6P75_NUM   = 16'd9;
  localparam logic [15:0] R_6P75_DEN   = 16'd128;
  localparam logic [15:0] R_3P375_NUM  = 16'd9;
  localparam logic [15:0] R_3P375_DEN  = 16'd256;
  localparam logic [15:0] R_1P6875_NUM = 16'd9;
  localparam logic [15:0] R_1P6875_DEN = 16'd512;
  localparam logic [15:0] R_4P0_NUM    = 16'd9;
  localparam logic [15:0] R_4P0_DEN    = 16'd216;

  // Default reset denominators, channel 0 in the LSBs
  localparam logic [95:0] DEN_INIT_DFLT = {R_6P75_DEN, R_4P0_DEN, R_1P6875_DEN,
                                           R_3P375_DEN, R_6P75_DEN, R_13P5_DEN};

  // Configuration state of one channel
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } cfg_state_e;

  // Width of a channel index; at least one bit
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/toaplan2_cen_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : toaplan2_cen_gen_if
//  Description : Configuration and enable-output bundle of the clock-enable
//                generator.
//                master : game-select logic (drives CFG_*, PAUSE; reads outputs)
//                slave  : the generator
//                Signals: CFG_WE, CFG_CH, CFG_NUM, CFG_DEN, CFG_IMM,
//                         PAUSE (only with TOAPLAN2_CEN_PAUSE_EN),
//                         CEN, CENB, CFG_PEND
//  Revision    : 1.0  initial release
// ============================================================================
interface toaplan2_cen_gen_if
  import toaplan2_cen_pkg::*;
#(
  parameter int NCH = 6,
  parameter int W   = 16
);
  localparam int CHW = ch_idx_w(NCH);

  logic           CFG_WE;
  logic [CHW-1:0] CFG_CH;
  logic [W-1:0]   CFG_NUM;
  logic [W-1:0]   CFG_DEN;
  logic           CFG_IMM;
`ifdef TOAPLAN2_CEN_PAUSE_EN
  logic           PAUSE;
`endif
  logic [NCH-1:0] CEN;
  logic [NCH-1:0] CENB;
  logic [NCH-1:0] CFG_PEND;

  modport master (
`ifdef TOAPLAN2_CEN_PAUSE_EN
    output PAUSE,
`endif
    output CFG_WE, CFG_CH, CFG_NUM, CFG_DEN, CFG_IMM,
    input  CEN, CENB, CFG_PEND
  );

  modport slave (
`ifdef TOAPLAN2_CEN_PAUSE_EN
    input  PAUSE,
`endif
    input  CFG_WE, CFG_CH, CFG_NUM, CFG_DEN, CFG_IMM,
    output CEN, CENB, CFG_PEND
  );

endinterface
`default_nettype wire

// File: rtl/toaplan2_cen_frac.sv
`default_nettype none
// ============================================================================
//  Module      : toaplan2_cen_frac
//  Description : One fractional clock-enable channel. Emits a one-cycle CEN
//                at f_clk*num/den and a half-phase CENB; the ratio can be
//                replaced immediately or deferred to the next CEN.
//  Ports       : CLK, RESET (async, active-high)
//                pause_i            hold phase, no pulses
//                cfg_we_i/cfg_imm_i write strobe for this channel / apply now
//                cfg_num_i/cfg_den_i new ratio
//                cen_o, cenb_o      registered enable pulses
//                cfg_pend_o         deferred ratio waiting
//  Revision    : 1.0  initial release
// ============================================================================
module toaplan2_cen_frac
  import toaplan2_cen_pkg::*;
#(
  parameter int           W        = 16,
  parameter logic [W-1:0] NUM_INIT = W'(9),
  parameter logic [W-1:0] DEN_INIT = W'(64)
)(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         pause_i,
  input  logic         cfg_we_i,
  input  logic         cfg_imm_i,
  input  logic [W-1:0] cfg_num_i,
  input  logic [W-1:0] cfg_den_i,
  output logic         cen_o,
  output logic         cenb_o,
  output logic         cfg_pend_o
);

  cfg_state_e   state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] num_q, num_d;
  logic [W-1:0] den_q, den_d;
  logic [W-1:0] snum_q, snum_d;
  logic [W-1:0] sden_q, sden_d;
  logic         cen_q, cen_d;
  logic         cenb_q, cenb_d;

  logic [W:0]   sum;
  logic [W-1:0] half;
  logic [W-1:0] acc_step;
  logic [W-1:0] acc_run;
  logic [W-1:0] new_num;
  logic [W-1:0] new_den;
  logic         wrap;
  logic         is_idle;
  logic         is_full;
  logic         apply;

  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, num_q};
    half     = den_q >> 1;
    is_idle  = (den_q == '0) || (num_q == '0);
    is_full  = (num_q >= den_q);
    wrap     = (sum >= {1'b0, den_q});
    // acc < den and num < den keep the true result inside [0, den), so the
    // W-bit modular difference is exact.
    acc_step = wrap ? (acc_q + num_q - den_q) : (acc_q + num_q);

    acc_run  = acc_q;
    cen_d    = 1'b0;
    cenb_d   = 1'b0;
    if (is_idle || pause_i) begin
      acc_run = acc_q;
    end else if (is_full) begin
      cen_d   = 1'b1;
      acc_run = '0;
    end else begin
      cen_d   = wrap;
      acc_run = acc_step;
      // A half-crossing found on a wrapping step lands on the CEN cycle and
      // is suppressed, so only the non-wrapping crossing can raise CENB.
      cenb_d  = !wrap && (acc_q < half) && (sum >= {1'b0, half});
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    snum_d  = snum_q;
    sden_d  = sden_q;
    acc_d   = acc_run;
    apply   = 1'b0;
    new_num = cfg_num_i;
    new_den = cfg_den_i;

    case (state_q)
      ST_IDLE: begin
        if (cfg_we_i) begin
          if (cfg_imm_i) begin
            apply = 1'b1;
          end else begin
            snum_d  = cfg_num_i;
            sden_d  = cfg_den_i;
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (cfg_we_i) begin
          if (cfg_imm_i) begin
            apply   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            snum_d  = cfg_num_i;
            sden_d  = cfg_den_i;
          end
        end else if (cen_d || is_idle) begin
          // Swap on the CEN step: this pulse used the old ratio and the
          // next accumulation uses the new one, so nothing is lost or doubled.
          apply   = 1'b1;
          new_num = snum_q;
          new_den = sden_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (apply) begin
      num_d = new_num;
      den_d = new_den;
      // Keep the phase unless it would break acc < den under the new ratio.
      if (acc_run >= new_den) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      num_q   <= NUM_INIT;
      den_q   <= DEN_INIT;
      snum_q  <= '0;
      sden_q  <= '0;
      cen_q   <= 1'b0;
      cenb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      num_q   <= num_d;
      den_q   <= den_d;
      snum_q  <= snum_d;
      sden_q  <= sden_d;
      cen_q   <= cen_d;
      cenb_q  <= cenb_d;
    end
  end

  assign cen_o      = cen_q;
  assign cenb_o     = cenb_q;
  assign cfg_pend_o = (state_q == ST_PEND);

endmodule
`default_nettype wire

// File: rtl/toaplan2_cen_gen.sv
`default_nettype none
// ============================================================================
//  Module      : toaplan2_cen_gen
//  Description : Multi-channel fractional clock-enable generator for the
//                Toaplan2 cores (pixel, pixel x2, YM2151 x2, OKI, aux).
//                Optional build macro TOAPLAN2_CEN_PAUSE_EN adds a PAUSE
//                input and a PAUSE_MASK parameter selecting frozen channels.
//  Ports       : CLK    system clock (96 MHz nominal)
//                RESET  asynchronous reset, active-high
//                cen_if slave side of toaplan2_cen_gen_if (config in,
//                       CEN/CENB/CFG_PEND out); CFG_CH >= NCH is ignored
//  Revision    : 1.0  initial release
// ============================================================================
module toaplan2_cen_gen
  import toaplan2_cen_pkg::*;
#(
  parameter int               NCH      = 6,
  parameter int               W        = 16,
  parameter logic [NCH*W-1:0] NUM_INIT = {NCH{W'(9)}},
  parameter logic [NCH*W-1:0] DEN_INIT = (NCH*W)'(DEN_INIT_DFLT)
`ifdef TOAPLAN2_CEN_PAUSE_EN
  ,
  parameter logic [NCH-1:0]   PAUSE_MASK = '1
`endif
)(
  input  logic                CLK,
  input  logic                RESET,
  toaplan2_cen_gen_if.slave   cen_if
);

  localparam int CHW = ch_idx_w(NCH);

  logic [NCH-1:0] cen_w;
  logic [NCH-1:0] cenb_w;
  logic [NCH-1:0] pend_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [CHW-1:0] C_IDX = CHW'(i);
    logic pause_w;
    logic we_w;

`ifdef TOAPLAN2_CEN_PAUSE_EN
    assign pause_w = cen_if.PAUSE & PAUSE_MASK[i];
`else
    assign pause_w = 1'b0;
`endif
    // Indices with no matching channel simply select nothing.
    assign we_w = cen_if.CFG_WE && (cen_if.CFG_CH == C_IDX);

    toaplan2_cen_frac #(
      .W        (W),
      .NUM_INIT (NUM_INIT[i*W +: W]),
      .DEN_INIT (DEN_INIT[i*W +: W])
    ) u_frac (
      .CLK        (CLK),
      .RESET      (RESET),
      .pause_i    (pause_w),
      .cfg_we_i   (we_w),
      .cfg_imm_i  (cen_if.CFG_IMM),
      .cfg_num_i  (cen_if.CFG_NUM),
      .cfg_den_i  (cen_if.CFG_DEN),
      .cen_o      (cen_w[i]),
      .cenb_o     (cenb_w[i]),
      .cfg_pend_o (pend_w[i])
    );
  end

  assign cen_if.CEN      = cen_w;
  assign cen_if.CENB     = cenb_w;
  assign cen_if.CFG_PEND = pend_w;

endmodule
`default_nettype wire

// File: tb/tb_toaplan2_cen_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toaplan2_cen_gen
//  Description : Scoreboard bench for toaplan2_cen_gen. A driver steps a
//                rational phase model each cycle and queues the expected
//                outputs; a monitor pops and compares after every clock.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_toaplan2_cen_gen;
  import toaplan2_cen_pkg::*;

  localparam int NCH = 6;
  localparam int W   = 16;
  localparam int CHW = ch_idx_w(NCH);

  typedef struct {
    logic [NCH-1:0] cen;
    logic [NCH-1:0] cenb;
    logic [NCH-1:0] pend;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  bit   pz = 1'b0;

  toaplan2_cen_gen_if #(.NCH(NCH), .W(W)) bus ();

  toaplan2_cen_gen #(.NCH(NCH), .W(W)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .cen_if (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cnt_cen[NCH];
  int cnt_cenb[NCH];
  exp_t exp_q[$];

  // Reference ratio state per channel
  longint m_num[NCH], m_den[NCH], m_acc[NCH], m_snum[NCH], m_sden[NCH];
  bit     m_pend[NCH];
  longint den0[NCH] = '{64, 128, 256, 512, 216, 128};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic zero_counts();
    for (int c = 0; c < NCH; c++) begin
      cnt_cen[c]  = 0;
      cnt_cenb[c] = 0;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_num[c]  = 9;
      m_den[c]  = den0[c];
      m_acc[c]  = 0;
      m_snum[c] = 0;
      m_sden[c] = 0;
      m_pend[c] = 1'b0;
    end
  endtask

  task automatic apply_ratio(input int c, input longint n, input longint d);
    m_num[c] = n;
    m_den[c] = d;
    if (m_acc[c] >= d) m_acc[c] = 0;
  endtask

  // Phase model: CEN when floor(phase/den) advances; CENB when the phase
  // shifted by half a period advances, unless CEN fires on the same step.
  task automatic model_step(input bit we, input int ch, input longint n, input longint d,
                            input bit imm, input bit pause, output exp_t e);
    for (int c = 0; c < NCH; c++) begin
      bit     cen, cenb, idle;
      longint a, nm, dn, h;
      cen  = 1'b0;
      cenb = 1'b0;
      a    = m_acc[c];
      nm   = m_num[c];
      dn   = m_den[c];
      idle = (nm == 0) || (dn == 0);
      if (!idle && !pause) begin
        if (nm >= dn) begin
          cen      = 1'b1;
          m_acc[c] = 0;
        end else begin
          h        = dn / 2;
          cen      = ((a + nm) / dn) != (a / dn);
          cenb     = (((a + nm + dn - h) / dn) != ((a + dn - h) / dn)) && !cen;
          m_acc[c] = (a + nm) % dn;
        end
      end
      if (we && ch == c) begin
        if (imm) begin
          apply_ratio(c, n, d);
          m_pend[c] = 1'b0;
        end else begin
          m_snum[c] = n;
          m_sden[c] = d;
          m_pend[c] = 1'b1;
        end
      end else if (m_pend[c] && (cen || idle)) begin
        apply_ratio(c, m_snum[c], m_sden[c]);
        m_pend[c] = 1'b0;
      end
      e.cen[c]  = cen;
      e.cenb[c] = cenb;
      e.pend[c] = m_pend[c];
    end
  endtask

  // Present inputs for the coming rising edge and queue its outcome.
  task automatic drive(input bit we, input int ch, input int n, input int d, input bit imm);
    exp_t e;
    bus.CFG_WE  = we;
    bus.CFG_CH  = CHW'(ch);
    bus.CFG_NUM = W'(n);
    bus.CFG_DEN = W'(d);
    bus.CFG_IMM = imm;
`ifdef TOAPLAN2_CEN_PAUSE_EN
    bus.PAUSE   = pz;
`endif
    model_step(we, ch, longint'(n), longint'(d), imm, pz, e);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit we, input int ch, input int n, input int d, input bit imm);
    @(negedge CLK);
    drive(we, ch, n, d, imm);
  endtask

  task automatic cyc_idle();
    cyc(1'b0, 0, 0, 0, 1'b0);
  endtask

  // Asynchronous reset pulse; outputs are checked before any clock edge.
  task automatic do_reset();
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_reset_outputs", longint'({bus.CEN, bus.CENB, bus.CFG_PEND}), 0);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    zero_counts();
    drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.CEN !== e.cen || bus.CENB !== e.cenb || bus.CFG_PEND !== e.pend) begin
          errors++;
          $display("FAIL outputs @%0t: CEN=%b CENB=%b PEND=%b expected CEN=%b CENB=%b PEND=%b",
                   $time, bus.CEN, bus.CENB, bus.CFG_PEND, e.cen, e.cenb, e.pend);
        end
        for (int c = 0; c < NCH; c++) begin
          if (bus.CEN[c] === 1'b1)  cnt_cen[c]++;
          if (bus.CENB[c] === 1'b1) cnt_cenb[c]++;
        end
      end
    end
  end

  // Stimulus
  initial begin
    bus.CFG_WE  = 1'b0;
    bus.CFG_CH  = '0;
    bus.CFG_NUM = '0;
    bus.CFG_DEN = '0;
    bus.CFG_IMM = 1'b0;
`ifdef TOAPLAN2_CEN_PAUSE_EN
    bus.PAUSE   = 1'b0;
`endif
    model_reset();
    zero_counts();

    // Default rates over 1152 cycles
    do_reset();
    repeat (1152) cyc_idle();
    chk("cen0_count", cnt_cen[0], 162);
    chk("cen1_count", cnt_cen[1], 81);
    chk("cen4_count", cnt_cen[4], 48);
    chk("cenb1_count", cnt_cenb[1], 81);

    // Deferred ratio change on ch1
    repeat (30) cyc_idle();
    cyc(1'b1, 1, 9, 64, 1'b0);
    cyc_idle();
    chk("ch1_pend_after_write", bus.CFG_PEND[1], 1);
    repeat (300) cyc_idle();

    // ch2 idle ratio, then resume
    cyc(1'b1, 2, 9, 0, 1'b1);
    cyc_idle();
    zero_counts();
    repeat (200) cyc_idle();
    chk("ch2_idle_cen", cnt_cen[2], 0);
    chk("ch2_idle_cenb", cnt_cenb[2], 0);
    cyc(1'b1, 2, 9, 256, 1'b1);
    zero_counts();
    repeat (1025) cyc_idle();
    chk("ch2_resume_cen", cnt_cen[2], 36);

    // ch5 num >= den, then an out-of-range channel
    cyc(1'b1, 5, 5, 5, 1'b1);
    cyc_idle();
    zero_counts();
    repeat (50) cyc_idle();
    chk("ch5_full_cen", cnt_cen[5], 50);
    chk("ch5_full_cenb", cnt_cenb[5], 0);
    cyc(1'b1, 7, 1, 1, 1'b1);
    repeat (20) cyc_idle();

    // Reset with ch3 pending
    cyc(1'b1, 3, 9, 256, 1'b0);
    cyc_idle();
    do_reset();
    repeat (1024) cyc_idle();
    chk("ch3_after_reset_cen", cnt_cen[3], 18);
    chk("ch3_after_reset_pend", bus.CFG_PEND[3], 0);

`ifdef TOAPLAN2_CEN_PAUSE_EN
    // Pause window
    repeat (40) cyc_idle();
    pz = 1'b1;
    cyc_idle();
    zero_counts();
    repeat (100) cyc_idle();
    pz = 1'b0;
    chk("pause_no_cen", cnt_cen[0] + cnt_cen[1] + cnt_cen[4], 0);
    repeat (200) cyc_idle();
`endif

    // Randomized reconfiguration
    for (int k = 0; k < 3000; k++) begin
`ifdef TOAPLAN2_CEN_PAUSE_EN
      if ($urandom_range(0, 63) == 0) pz = ~pz;
`endif
      if ($urandom_range(0, 7) == 0)
        cyc(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
            int'($urandom_range(0, 300)), 1'($urandom_range(0, 1)));
      else
        cyc_idle();
    end
    pz = 1'b0;

    @(posedge CLK);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
